pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 35 +++
 rtl/pipe_hazard_ctrl_load_use_detect.sv | 18 +
 rtl/pipe_hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Control bundle field order matches the pipeline-register order from PC to MEM/WB.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } ctrl_state_t;

    localparam logic [4:0]  XZR_REG     = 5'd31;
    localparam int unsigned STALL_CNT_W = 3;
    localparam int unsigned WAIT_CNT_W  = 10;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_flush;
        logic ex_mem_write;
        logic mem_wb_bubble;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam pipe_ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam pipe_ctrl_t CTRL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam pipe_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // XZR reads as zero and is never really written, so it never creates a dependency.
    function automatic logic reg_depends(input logic [4:0] producer, input logic [4:0] consumer);
        return (producer != XZR_REG) && (producer == consumer);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the sources in ID.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rn,
    input  logic [4:0] id_rm,
    input  logic       id_uses_rm,
    output logic       hazard
);

    always_comb begin
        hazard = ex_memread &&
                 (reg_depends(ex_rd, id_rn) || (id_uses_rm && reg_depends(ex_rd, id_rm)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, branch flushes, memory waits.
// Optional performance counters are enabled with `define PIPE_HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT       = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rn,
    input  logic [4:0] id_rm,
    input  logic       id_uses_rm,
    input  logic [4:0] ex_rd,
    input  logic       ex_memread,
    input  logic       ex_branch_taken,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       if_id_flush,
    output logic       id_ex_write,
    output logic       id_ex_flush,
    output logic       ex_mem_write,
    output logic       mem_wb_bubble,
    output logic [1:0] ctrl_state,
    output logic       mem_timeout
`ifdef PIPE_HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    localparam logic [STALL_CNT_W-1:0] STALL_RELOAD = STALL_CNT_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [WAIT_CNT_W-1:0]  WAIT_LIMIT   = WAIT_CNT_W'(MEM_TIMEOUT);

    ctrl_state_t            state_q, state_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic                   mem_timeout_q;
    logic                   hazard;
    logic                   mem_stall;
    pipe_ctrl_t             ctrl;

    load_use_detect u_load_use_detect (
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .id_rn      (id_rn),
        .id_rm      (id_rm),
        .id_uses_rm (id_uses_rm),
        .hazard     (hazard)
    );

    assign mem_stall = mem_req && !mem_ready;

    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        ctrl        = CTRL_RUN;

        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    ctrl       = CTRL_FREEZE;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_CNT_W'(1);
                end else if (ex_branch_taken) begin
                    ctrl = CTRL_FLUSH;
                end else if (hazard) begin
                    ctrl = CTRL_STALL;
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_d     = LOAD_STALL;
                        stall_cnt_d = STALL_RELOAD;
                    end
                end
            end

            LOAD_STALL: begin
                if (mem_stall) begin
                    // stall_cnt is held so the remaining bubbles resume after the wait
                    ctrl       = CTRL_FREEZE;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_CNT_W'(1);
                end else if (ex_branch_taken) begin
                    ctrl        = CTRL_FLUSH;
                    state_d     = RUN;
                    stall_cnt_d = '0;
                end else begin
                    ctrl = CTRL_STALL;
                    if (stall_cnt_q <= STALL_CNT_W'(1)) begin
                        state_d     = RUN;
                        stall_cnt_d = '0;
                    end else begin
                        stall_cnt_d = stall_cnt_q - 1'b1;
                    end
                end
            end

            MEM_WAIT: begin
                if (mem_ready) begin
                    wait_cnt_d = '0;
                    state_d    = (stall_cnt_q != '0) ? LOAD_STALL : RUN;
                end else begin
                    ctrl = CTRL_FREEZE;
                    if (wait_cnt_q < WAIT_LIMIT) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d     = RUN;
                stall_cnt_d = '0;
                wait_cnt_d  = '0;
            end
        endcase

        if (reset) begin
            ctrl = CTRL_FREEZE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            stall_cnt_q   <= '0;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            if (wait_cnt_d == WAIT_LIMIT) begin
                mem_timeout_q <= 1'b1;
            end
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign if_id_write   = ctrl.if_id_write;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_write   = ctrl.id_ex_write;
    assign id_ex_flush   = ctrl.id_ex_flush;
    assign ex_mem_write  = ctrl.ex_mem_write;
    assign mem_wb_bubble = ctrl.mem_wb_bubble;
    assign ctrl_state    = state_q;
    assign mem_timeout   = mem_timeout_q;

`ifdef PIPE_HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!ctrl.pc_write) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (ctrl.if_id_flush) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: single-cycle vector table plus multi-cycle sequences.
module tb_pipe_hazard_ctrl;

    localparam logic [6:0] O_RUN    = 7'b1101010;
    localparam logic [6:0] O_STALL  = 7'b0001110;
    localparam logic [6:0] O_FLUSH  = 7'b1111110;
    localparam logic [6:0] O_FREEZE = 7'b0000001;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rn, id_rm, ex_rd;
    logic       id_uses_rm, ex_memread, ex_branch_taken, mem_req, mem_ready;

    logic pc_write_a, if_id_write_a, if_id_flush_a, id_ex_write_a, id_ex_flush_a, ex_mem_write_a, mem_wb_bubble_a;
    logic pc_write_b, if_id_write_b, if_id_flush_b, id_ex_write_b, id_ex_flush_b, ex_mem_write_b, mem_wb_bubble_b;
    logic [1:0] ctrl_state_a, ctrl_state_b;
    logic       mem_timeout_a, mem_timeout_b;
`ifdef PIPE_HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_a, flush_count_a, stall_cycles_b, flush_count_b;
`endif

    logic [6:0] out_a, out_b;
    assign out_a = {pc_write_a, if_id_write_a, if_id_flush_a, id_ex_write_a, id_ex_flush_a, ex_mem_write_a, mem_wb_bubble_a};
    assign out_b = {pc_write_b, if_id_write_b, if_id_flush_b, id_ex_write_b, id_ex_flush_b, ex_mem_write_b, mem_wb_bubble_b};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl u_dut_a (
        .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write_a), .if_id_write(if_id_write_a), .if_id_flush(if_id_flush_a),
        .id_ex_write(id_ex_write_a), .id_ex_flush(id_ex_flush_a), .ex_mem_write(ex_mem_write_a),
        .mem_wb_bubble(mem_wb_bubble_a), .ctrl_state(ctrl_state_a), .mem_timeout(mem_timeout_a)
`ifdef PIPE_HAZARD_PERF_CNT_EN
        , .stall_cycles(stall_cycles_a), .flush_count(flush_count_a)
`endif
    );

    pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(8)) u_dut_b (
        .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write_b), .if_id_write(if_id_write_b), .if_id_flush(if_id_flush_b),
        .id_ex_write(id_ex_write_b), .id_ex_flush(id_ex_flush_b), .ex_mem_write(ex_mem_write_b),
        .mem_wb_bubble(mem_wb_bubble_b), .ctrl_state(ctrl_state_b), .mem_timeout(mem_timeout_b)
`ifdef PIPE_HAZARD_PERF_CNT_EN
        , .stall_cycles(stall_cycles_b), .flush_count(flush_count_b)
`endif
    );

    typedef struct {
        string      name;
        logic       memread;
        logic [4:0] rd;
        logic [4:0] rn;
        logic [4:0] rm;
        logic       uses_rm;
        logic       br;
        logic       mreq;
        logic       mrdy;
        logic [6:0] exp_out;
        logic [1:0] exp_next;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        ex_memread = 1'b0; ex_rd = 5'd0; id_rn = 5'd0; id_rm = 5'd0; id_uses_rm = 1'b0;
        ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic hazard_in();
        idle();
        ex_memread = 1'b1; ex_rd = 5'd3; id_rn = 5'd3; id_rm = 5'd9;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //          name             mrd  rd     rn     rm     use  br   mreq mrdy  out       next
        tbl[0] = '{"idle",          1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN,    2'd0};
        tbl[1] = '{"load_use_rn",   1'b1, 5'd3, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, O_STALL,  2'd0};
        tbl[2] = '{"xzr_rn",        1'b1, 5'd31,5'd31,5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_RUN,    2'd0};
        tbl[3] = '{"rm_unused",     1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN,    2'd0};
        tbl[4] = '{"rm_used",       1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_STALL,  2'd0};
        tbl[5] = '{"not_load",      1'b0, 5'd3, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, O_RUN,    2'd0};
        tbl[6] = '{"branch_hazard", 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_FLUSH,  2'd0};
        tbl[7] = '{"mem_zero_wait", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, O_RUN,    2'd0};
        tbl[8] = '{"mem_over_all",  1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, O_FREEZE, 2'd2};
        tbl[9] = '{"xzr_rm",        1'b1, 5'd31,5'd1, 5'd31,1'b1, 1'b0, 1'b0, 1'b0, O_RUN,    2'd0};

        reset = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outs_a", out_a, O_FREEZE);
        chk("reset_outs_b", out_b, O_FREEZE);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_state_a", ctrl_state_a, 0);
        chk("reset_state_b", ctrl_state_b, 0);
        chk("reset_timeout_b", mem_timeout_b, 0);
        chk("post_reset_outs_a", out_a, O_RUN);

        for (int i = 0; i < 10; i++) begin
            do_reset();
            ex_memread = tbl[i].memread; ex_rd = tbl[i].rd; id_rn = tbl[i].rn; id_rm = tbl[i].rm;
            id_uses_rm = tbl[i].uses_rm; ex_branch_taken = tbl[i].br;
            mem_req = tbl[i].mreq; mem_ready = tbl[i].mrdy;
            #1;
            chk({tbl[i].name, "_outs"}, out_a, tbl[i].exp_out);
            @(negedge clk);
            #1;
            chk({tbl[i].name, "_next"}, ctrl_state_a, tbl[i].exp_next);
        end

        // Three-cycle load-use stall on the LOAD_STALL_CYCLES=3 instance.
        do_reset();
        hazard_in();
        #1;
        chk("ls3_c1_outs", out_b, O_STALL);
        chk("ls3_c1_state", ctrl_state_b, 0);
        @(negedge clk);
        idle();
        #1;
        chk("ls3_c2_outs", out_b, O_STALL);
        chk("ls3_c2_state", ctrl_state_b, 1);
        @(negedge clk);
        #1;
        chk("ls3_c3_outs", out_b, O_STALL);
        chk("ls3_c3_state", ctrl_state_b, 1);
        @(negedge clk);
        #1;
        chk("ls3_c4_outs", out_b, O_RUN);
        chk("ls3_c4_state", ctrl_state_b, 0);
`ifdef PIPE_HAZARD_PERF_CNT_EN
        chk("perf_stall_cycles", stall_cycles_b, 3);
        chk("perf_flush_zero", flush_count_b, 0);
        @(negedge clk);
        ex_branch_taken = 1'b1;
        @(negedge clk);
        idle();
        #1;
        chk("perf_flush_one", flush_count_b, 1);
`endif

        // Memory wait of four cycles, release on the fifth.
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            mem_req = 1'b1; mem_ready = 1'b0;
            #1;
            chk($sformatf("mw_c%0d_outs", i), out_b, O_FREEZE);
            chk($sformatf("mw_c%0d_state", i), ctrl_state_b, (i == 1) ? 0 : 2);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        chk("mw_release_outs", out_b, O_RUN);
        chk("mw_release_state", ctrl_state_b, 2);
        @(negedge clk);
        idle();
        #1;
        chk("mw_after_state", ctrl_state_b, 0);
        chk("mw_no_timeout", mem_timeout_b, 0);

        // Load stall interrupted by a memory wait resumes its remaining bubbles.
        do_reset();
        hazard_in();
        #1;
        chk("lsmw_c1_outs", out_b, O_STALL);
        @(negedge clk);
        idle();
        mem_req = 1'b1;
        #1;
        chk("lsmw_c2_outs", out_b, O_FREEZE);
        chk("lsmw_c2_state", ctrl_state_b, 1);
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        chk("lsmw_c3_outs", out_b, O_RUN);
        chk("lsmw_c3_state", ctrl_state_b, 2);
        @(negedge clk);
        idle();
        #1;
        chk("lsmw_c4_outs", out_b, O_STALL);
        chk("lsmw_c4_state", ctrl_state_b, 1);
        @(negedge clk);
        #1;
        chk("lsmw_c5_outs", out_b, O_STALL);
        @(negedge clk);
        #1;
        chk("lsmw_c6_outs", out_b, O_RUN);
        chk("lsmw_c6_state", ctrl_state_b, 0);

        // Watchdog: MEM_TIMEOUT=8, flag visible once eight frozen cycles have elapsed.
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            mem_req = 1'b1; mem_ready = 1'b0;
            #1;
            chk($sformatf("to_c%0d_flag", i), mem_timeout_b, (i >= 9) ? 1 : 0);
            chk($sformatf("to_c%0d_outs", i), out_b, O_FREEZE);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        chk("to_release_outs", out_b, O_RUN);
        @(negedge clk);
        idle();
        #1;
        chk("to_sticky_flag", mem_timeout_b, 1);
        chk("to_sticky_state", ctrl_state_b, 0);
        chk("to_default_inst_flag", mem_timeout_a, 0);
        do_reset();
        #1;
        chk("to_cleared_by_reset", mem_timeout_b, 0);

        // Reset while in LOAD_STALL with stall_cnt=2.
        do_reset();
        hazard_in();
        @(negedge clk);
        idle();
        #1;
        chk("rst_mid_state_before", ctrl_state_b, 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_outs", out_b, O_FREEZE);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_mid_state_after", ctrl_state_b, 0);
        chk("rst_mid_outs_after", out_b, O_RUN);
        mem_req = 1'b1;
        @(negedge clk);
        mem_ready = 1'b1;
        @(negedge clk);
        idle();
        #1;
        chk("rst_mid_stall_cnt_cleared", ctrl_state_b, 0);
        chk("rst_mid_no_bubble", out_b, O_RUN);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
